// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
// Imported by the interface, the sck generator and the top.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } spi_mst_state_t;

  localparam int SPI_BITS        = 8;
  localparam int SPI_EDGES       = 16;
  localparam int SPI_MIN_CLK_DIV = 2;

endpackage

// File: rtl/spi_master_if.sv
// Bus-side handshake of the SPI master.
// master: requester side, slave: the spi_master block.
interface spi_master_if;
  import spi_pkg::*;

  logic                start;
  logic [SPI_BITS-1:0] data_tx;
  logic                cpol;
  logic                cpha;
  logic                msb_first;
  logic [SPI_BITS-1:0] data_rx;
  logic                busy;
  logic                done;

  modport master (
    output start,
    output data_tx,
    output cpol,
    output cpha,
    output msb_first,
    input  data_rx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_tx,
    input  cpol,
    input  cpha,
    input  msb_first,
    output data_rx,
    output busy,
    output done
  );

endinterface

// File: rtl/spi_sck_gen.sv
// Half-period divider and sck edge counter.
// edge_num is the number of the edge the current tick makes.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       edge_en,
  output logic       tick,
  output logic [4:0] edge_num,
  output logic       leading,
  output logic       last_edge
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [4:0]    edge_cnt;

  assign tick      = run && (div_cnt == DIV_MAX);
  assign edge_num  = edge_cnt + 5'd1;
  assign leading   = edge_num[0];
  assign last_edge = (edge_num == 5'(SPI_EDGES));

  // Divider free-runs while active; both counters clear when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (!run) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick && edge_en)
        edge_cnt <= edge_num;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Single-byte full-duplex SPI master, all CPOL/CPHA modes.
// Edge 1 falls on the SETUP tick so cs is low for 17 half-periods.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.slave  bus,
  output logic         sck,
  output logic         mosi,
  input  logic         miso,
  output logic         cs
);

  spi_mst_state_t state;

  logic [SPI_BITS-1:0] tx_sr;
  logic [SPI_BITS-1:0] rx_sr;
  logic [SPI_BITS-1:0] data_rx_q;
  logic                busy_q;
  logic                done_q;
  logic                cpol_q;
  logic                cpha_q;
  logic                msb_q;
  logic                miso_q1;
  logic                miso_s;

  logic       run;
  logic       edge_en;
  logic       tick;
  logic [4:0] edge_num;
  logic       leading;
  logic       last_edge;
  logic       shift_en;
  logic       sample_en;

  assign run     = (state != IDLE);
  assign edge_en = (state == SETUP) || (state == XFER);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .edge_en   (edge_en),
    .tick      (tick),
    .edge_num  (edge_num),
    .leading   (leading),
    .last_edge (last_edge)
  );

  assign mosi        = msb_q ? tx_sr[SPI_BITS-1] : tx_sr[0];
  assign bus.data_rx = data_rx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  // Two-flop synchronizer for the asynchronous miso pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_q1 <= 1'b0;
      miso_s  <= 1'b0;
    end else begin
      miso_q1 <= miso;
      miso_s  <= miso_q1;
    end
  end

  // Pick shift/sample per edge; first bit needs no shift in either phase.
  always_comb begin
    shift_en  = 1'b0;
    sample_en = 1'b0;
    if (tick && edge_en) begin
      if (cpha_q) begin
        sample_en = !leading;
        shift_en  = leading && (edge_num != 5'd1);
      end else begin
        sample_en = leading;
        shift_en  = !leading && !last_edge;
      end
    end
  end

  // Transfer FSM with registered cs/sck/busy/done and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b1;
      sck       <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      data_rx_q <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      msb_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          cs     <= 1'b1;
          busy_q <= 1'b0;
          sck    <= bus.cpol;
          if (bus.start) begin
            tx_sr  <= bus.data_tx;
            cpol_q <= bus.cpol;
            cpha_q <= bus.cpha;
            msb_q  <= bus.msb_first;
            cs     <= 1'b0;
            busy_q <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP, XFER: begin
          if (tick) begin
            sck <= ~sck;
            if (shift_en)
              tx_sr <= msb_q ? {tx_sr[SPI_BITS-2:0], 1'b0}
                             : {1'b0, tx_sr[SPI_BITS-1:1]};
            if (sample_en)
              rx_sr <= msb_q ? {rx_sr[SPI_BITS-2:0], miso_s}
                             : {miso_s, rx_sr[SPI_BITS-1:1]};
            state <= last_edge ? HOLD : XFER;
          end
        end
        HOLD: begin
          if (tick) begin
            cs        <= 1'b1;
            data_rx_q <= rx_sr;
            done_q    <= 1'b1;
            state     <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master with a behavioural SPI slave model.
// Timing counts cycle 1 as the cycle after the edge sampling start.
module tb_spi_master;

  localparam int CLK_DIV = 4;
  localparam int DONE_CYC = 1 + 17 * CLK_DIV;
  localparam int FREE_CYC = 1 + 18 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck;
  logic mosi;
  logic miso;
  logic cs;

  spi_master_if bus();

  spi_master #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso),
    .cs   (cs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave model: bit index advances on shift edges, mosi is
  // recorded on sample edges, all from the mode rules.
  logic [7:0] sl_tx = 8'h00;
  bit         m_cpha = 1'b0;
  bit         m_msb = 1'b1;
  int         sl_edge = 0;
  int         sl_idx = 0;
  bit         sl_q[$];
  int         cs_falls = 0;
  int         done_cnt = 0;

  always @(negedge cs) begin
    sl_edge = 0;
    sl_idx  = 0;
    sl_q.delete();
    cs_falls++;
  end

  always @(sck) begin
    if (cs === 1'b0) begin
      sl_edge++;
      if ((sl_edge % 2 == 1) == (m_cpha == 1'b0))
        sl_q.push_back(mosi);
      else if (m_cpha ? (sl_edge > 1) : (sl_edge < 16))
        sl_idx++;
    end
  end

  function automatic logic sl_bit(logic [7:0] b, int idx,
                                  bit msb, logic c);
    logic [2:0] i;
    if (c !== 1'b0 || idx > 7 || idx < 0) return 1'b0;
    i = 3'(idx);
    return msb ? b[3'd7 - i] : b[i];
  endfunction

  assign miso = sl_bit(sl_tx, sl_idx, m_msb, cs);

  always @(negedge clk)
    if (bus.done === 1'b1) done_cnt++;

  function automatic logic [7:0] sl_rx_byte(bit msb);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8 && i < sl_q.size(); i++)
      if (msb) r[7-i] = sl_q[i];
      else     r[i]   = sl_q[i];
    return r;
  endfunction

  logic c1_cs;
  logic c1_busy;
  logic c1_sck;
  logic idle_sck;

  task automatic xfer(input logic [7:0] tx, input logic [7:0] stx,
                      input bit cpol, input bit cpha, input bit msb,
                      input int extra_cyc,
                      output int done_cyc, output int busy_cyc,
                      output logic [7:0] rx);
    @(negedge clk);
    sl_tx = stx;
    m_cpha = cpha;
    m_msb = msb;
    bus.data_tx = tx;
    bus.cpol = cpol;
    bus.cpha = cpha;
    bus.msb_first = msb;
    @(negedge clk);
    idle_sck = sck;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_cyc = 0;
    busy_cyc = 0;
    rx = 8'h00;
    for (int cyc = 1; cyc < 200 && busy_cyc == 0; cyc++) begin
      if (cyc == 1) begin
        c1_cs = cs;
        c1_busy = bus.busy;
        c1_sck = sck;
      end
      if (bus.done === 1'b1 && done_cyc == 0) begin
        done_cyc = cyc;
        rx = bus.data_rx;
      end
      if (bus.busy === 1'b0) busy_cyc = cyc;
      if (cyc == extra_cyc) begin
        bus.start = 1'b1;
        bus.data_tx = 8'hFF;
        bus.cpha = ~cpha;
        bus.msb_first = ~msb;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.data_tx = 8'h00;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.msb_first = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cs !== 1'b1) begin
      errors++; $display("FAIL reset_cs got %b exp 1", cs);
    end
    checks++;
    if (sck !== 1'b0) begin
      errors++; $display("FAIL reset_sck got %b exp 0", sck);
    end
    checks++;
    if (mosi !== 1'b0) begin
      errors++; $display("FAIL reset_mosi got %b exp 0", mosi);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b exp 0", bus.done);
    end
    checks++;
    if (bus.data_rx !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx got %h exp 00", bus.data_rx);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mode0();
    int dc, bc, d0;
    logic [7:0] rx;
    d0 = done_cnt;
    xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b1, -1, dc, bc, rx);
    checks++;
    if (c1_cs !== 1'b0 || c1_busy !== 1'b1) begin
      errors++;
      $display("FAIL m0_cycle1 cs %b busy %b exp 0 1", c1_cs, c1_busy);
    end
    checks++;
    if (dc != DONE_CYC) begin
      errors++; $display("FAIL m0_done_cyc got %0d exp %0d", dc, DONE_CYC);
    end
    checks++;
    if (bc != FREE_CYC) begin
      errors++; $display("FAIL m0_busy_cyc got %0d exp %0d", bc, FREE_CYC);
    end
    checks++;
    if (rx !== 8'h3C) begin
      errors++; $display("FAIL m0_rx got %h exp 3c", rx);
    end
    checks++;
    if (sl_q.size() != 8 || sl_rx_byte(1'b1) !== 8'hA5) begin
      errors++;
      $display("FAIL m0_mosi n %0d byte %h exp 8 a5",
               sl_q.size(), sl_rx_byte(1'b1));
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL m0_done_cnt got %0d exp 1", done_cnt - d0);
    end
  endtask

  task automatic test_mode3();
    int dc, bc;
    logic [7:0] rx;
    xfer(8'h81, 8'h0F, 1'b1, 1'b1, 1'b0, -1, dc, bc, rx);
    checks++;
    if (idle_sck !== 1'b1 || c1_sck !== 1'b1 || sck !== 1'b1) begin
      errors++;
      $display("FAIL m3_sck_idle got %b %b %b exp 1 1 1",
               idle_sck, c1_sck, sck);
    end
    checks++;
    if (rx !== 8'h0F) begin
      errors++; $display("FAIL m3_rx got %h exp 0f", rx);
    end
    checks++;
    if (sl_q.size() != 8 || sl_rx_byte(1'b0) !== 8'h81) begin
      errors++;
      $display("FAIL m3_mosi n %0d byte %h exp 8 81",
               sl_q.size(), sl_rx_byte(1'b0));
    end
  endtask

  task automatic test_start_busy();
    int dc, bc, f0, d0;
    logic [7:0] rx;
    f0 = cs_falls;
    d0 = done_cnt;
    xfer(8'hA5, 8'h5A, 1'b0, 1'b0, 1'b1, 20, dc, bc, rx);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (cs_falls - f0 != 1 || cs !== 1'b1) begin
      errors++;
      $display("FAIL busy_cs_windows got %0d cs %b exp 1 1",
               cs_falls - f0, cs);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++; $display("FAIL busy_done_cnt got %0d exp 1", done_cnt - d0);
    end
    checks++;
    if (sl_rx_byte(1'b1) !== 8'hA5) begin
      errors++; $display("FAIL busy_sent got %h exp a5", sl_rx_byte(1'b1));
    end
    checks++;
    if (rx !== 8'h5A || dc != DONE_CYC) begin
      errors++;
      $display("FAIL busy_rx got %h at %0d exp 5a at %0d", rx, dc, DONE_CYC);
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc, d0;
    logic [7:0] rx, t, s;
    @(negedge clk);
    sl_tx = 8'h77;
    m_cpha = 1'b0;
    m_msb = 1'b1;
    bus.data_tx = 8'h96;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.msb_first = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (cs !== 1'b1 || sck !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pins cs %b sck %b busy %b exp 1 0 0",
               cs, sck, bus.busy);
    end
    checks++;
    if (bus.data_rx !== 8'h00 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rx got %h done %b exp 00 0",
               bus.data_rx, bus.done);
    end
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cs !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_start cs %b busy %b exp 1 0", cs, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0 || cs !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_done got %0d cs %b exp 0 1", done_cnt - d0, cs);
    end
    t = 8'($urandom);
    s = 8'($urandom);
    xfer(t, s, 1'b0, 1'b1, 1'b1, -1, dc, bc, rx);
    checks++;
    if (rx !== s || sl_rx_byte(1'b1) !== t || dc != DONE_CYC) begin
      errors++;
      $display("FAIL rst_after rx %h sent %h dc %0d exp %h %h %0d",
               rx, sl_rx_byte(1'b1), dc, s, t, DONE_CYC);
    end
  endtask

  task automatic test_modes_random();
    int dc, bc;
    logic [7:0] rx, t, s;
    bit cp, ch, mb;
    for (int m = 0; m < 8; m++) begin
      for (int r = 0; r < 2; r++) begin
        cp = m[0];
        ch = m[1];
        mb = m[2];
        t = 8'($urandom);
        s = 8'($urandom);
        xfer(t, s, cp, ch, mb, -1, dc, bc, rx);
        checks++;
        if (rx !== s) begin
          errors++;
          $display("FAIL rnd_rx mode %0d got %h exp %h", m, rx, s);
        end
        checks++;
        if (sl_q.size() != 8 || sl_rx_byte(mb) !== t) begin
          errors++;
          $display("FAIL rnd_sent mode %0d got %h exp %h",
                   m, sl_rx_byte(mb), t);
        end
        checks++;
        if (dc != DONE_CYC || bc != FREE_CYC) begin
          errors++;
          $display("FAIL rnd_timing mode %0d got %0d %0d exp %0d %0d",
                   m, dc, bc, DONE_CYC, FREE_CYC);
        end
        checks++;
        if (sck !== cp) begin
          errors++;
          $display("FAIL rnd_sck_end mode %0d got %b exp %b", m, sck, cp);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_start_busy();
    test_reset_mid();
    test_modes_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
